divider_ctrl: RTL

Programmable, synchronous clock-enable controller that sequences the board's frequency-division resource. A single counter replaces the fixed ripple chain and produces a selectable divide-by-2^(sel+1) square wave plus a one-cycle tick enable. The block has a run/stop/one-shot state machine and a config handshake, so multiple consumers can retime safely. It sits between the system clock and downstream timers/display scanners, which should use `tick` as an enable, not as a clock.

---
 rtl/divider_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/divider_ctrl.sv
// divider_ctrl: programmable clock-enable controller.
// One half-period counter produces a divide-by-2^(sel+1) square wave
// (divclock) and a one-cycle enable (tick) that is high in the same cycle
// divclock rises. A run/stop/one-shot FSM sequences the divider. A
// valid/ready config port lets the divider be retimed safely: configs
// offered while running are held and applied only on a full-period boundary.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start, stop         begin a run from IDLE / abort a run
//   cfg_valid/cfg_ready config handshake (transfer when both high)
//   cfg_sel             half-period H = 2^cfg_sel clk cycles
//   cfg_oneshot         1: run for cfg_burst ticks then stop; 0: continuous
//   cfg_burst           one-shot tick count, 0 means 2^BURST_W
//   divclock            registered divided square wave, period 2H
//   tick                one-cycle pulse with each divclock 0->1
//   busy                high while RUN or FINISH
//   done                one-cycle pulse when a one-shot run completes
module divider_ctrl #(
  parameter int SEL_W   = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [SEL_W-1:0]   cfg_sel,
  input  logic               cfg_oneshot,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic               divclock,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0]   sel;
    logic               oneshot;
    logic [BURST_W-1:0] burst;
  } cfg_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BURST_W:0]   tick_cnt;
  cfg_t               act;
  cfg_t               pend;
  logic               pend_valid;

  cfg_t               cfg_in;
  cfg_t               next_act;
  logic               cfg_fire;
  logic [CNT_W-1:0]   half_m1;
  logic               wrap;
  logic               rise;
  logic               fall;

  // Burst of 0 encodes 2^BURST_W, hence the extra counter bit.
  function automatic logic [BURST_W:0] burst_count(input logic [BURST_W-1:0] b);
    return (b == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, b};
  endfunction

  // Depends on registered state only, never on inputs.
  assign cfg_ready = (state == IDLE) || !pend_valid;
  assign cfg_fire  = cfg_valid && cfg_ready;

  assign cfg_in.sel     = cfg_sel;
  assign cfg_in.oneshot = cfg_oneshot;
  assign cfg_in.burst   = cfg_burst;

  // Config that becomes active when a run ends: a pending one wins; if none
  // is pending, cfg_ready is high and an offer in the same cycle is taken.
  always_comb begin
    next_act = act;
    if (pend_valid)
      next_act = pend;
    else if (cfg_fire)
      next_act = cfg_in;
  end

  assign half_m1 = (CNT_W'(1) << act.sel) - CNT_W'(1);
  assign wrap    = (cnt == half_m1);
  assign rise    = wrap && !divclock;
  assign fall    = wrap && divclock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      divclock    <= 1'b0;
      tick        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pend_valid  <= 1'b0;
      pend        <= '0;
      act.sel     <= '1;
      act.oneshot <= 1'b0;
      act.burst   <= BURST_W'(1);
      tick_cnt    <= (BURST_W+1)'(1);
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_fire)
            act <= cfg_in;
          if (start && !stop) begin
            state    <= RUN;
            cnt      <= '0;
            divclock <= 1'b0;
            busy     <= 1'b1;
            tick_cnt <= burst_count(cfg_fire ? cfg_burst : act.burst);
          end
        end

        RUN, FINISH: begin
          if (stop) begin
            // Abort wins over start and over one-shot completion.
            state      <= IDLE;
            cnt        <= '0;
            divclock   <= 1'b0;
            busy       <= 1'b0;
            act        <= next_act;
            pend_valid <= 1'b0;
          end else begin
            if (cfg_fire) begin
              pend       <= cfg_in;
              pend_valid <= 1'b1;
            end

            if (wrap) begin
              cnt      <= '0;
              divclock <= !divclock;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end

            if (rise) begin
              tick <= 1'b1;
              if (state == RUN && act.oneshot) begin
                tick_cnt <= tick_cnt - (BURST_W+1)'(1);
                if (tick_cnt == (BURST_W+1)'(1))
                  state <= FINISH;
              end
            end

            // Falling edge closes a full period: safe point to retime.
            if (fall) begin
              if (state == FINISH) begin
                state      <= IDLE;
                busy       <= 1'b0;
                done       <= 1'b1;
                act        <= next_act;
                pend_valid <= 1'b0;
              end else if (pend_valid) begin
                act        <= pend;
                pend_valid <= 1'b0;
                tick_cnt   <= burst_count(pend.burst);
              end
            end
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= '0;
          divclock <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
